lock_button_conditioner: RTL and testbench



---
 rtl/lock_pkg.sv | 17 +
 rtl/lock_debounce_ch.sv | 69 ++++++
 rtl/lock_button_conditioner.sv | 66 ++++++
 tb/tb_lock_button_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock slice:
// debounce lengths and the lock FSM state encodings.
package lock_pkg;

    localparam int LOCK_DEBOUNCE_SIM   = 4;
    localparam int LOCK_DEBOUNCE_BOARD = 1000000;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101
    } lock_state_e;

endpackage

// File: rtl/lock_debounce_ch.sv
// One pushbutton channel: two-flop synchroniser, debounce counter,
// stable level and release-arming, with a combinational press candidate.
module lock_debounce_ch
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fill_q, fill_d;

    always_comb begin
        stable_d = stable_q;
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        fill_d   = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;

        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // The reset zeros in the synchroniser are not a real release;
        // only a 0 that has travelled in from the pin arms the channel.
        if (fill_q == 2'd2 && !sync2_q) begin
            armed_d = 1'b1;
        end

        rise = stable_d & ~stable_q & armed_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            fill_q   <= 2'd0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/lock_button_conditioner.sv
// Conditions the two raw lock buttons into single-cycle press pulses,
// flagging simultaneous presses instead of passing either through.
module lock_button_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_x,
    input  logic btn_x1,
    output logic x,
    output logic x1,
    output logic db_x,
    output logic db_x1,
    output logic both_err
);

    logic rise_x, rise_x1;
    logic x_q, x_d;
    logic x1_q, x1_d;
    logic both_q, both_d;

    lock_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_x (
        .CLK  (CLK),
        .RST  (RST),
        .btn  (btn_x),
        .level(db_x),
        .rise (rise_x)
    );

    lock_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_x1 (
        .CLK  (CLK),
        .RST  (RST),
        .btn  (btn_x1),
        .level(db_x1),
        .rise (rise_x1)
    );

    always_comb begin
        x_d    = rise_x & ~rise_x1;
        x1_d   = rise_x1 & ~rise_x;
        both_d = rise_x & rise_x1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            x_q    <= 1'b0;
            x1_q   <= 1'b0;
            both_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            x1_q   <= x1_d;
            both_q <= both_d;
        end
    end

    assign x        = x_q;
    assign x1       = x1_q;
    assign both_err = both_q;

endmodule

// File: tb/tb_lock_button_conditioner.sv
// Randomised and directed bench for lock_button_conditioner with a
// queue-based scoreboard fed by a behavioural button model.
module tb_lock_button_conditioner;
    import lock_pkg::*;

    localparam int N = LOCK_DEBOUNCE_SIM;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic btn_x = 1'b0;
    logic btn_x1 = 1'b0;
    logic x, x1, db_x, db_x1, both_err;

    lock_button_conditioner #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .btn_x   (btn_x),
        .btn_x1  (btn_x1),
        .x       (x),
        .x1      (x1),
        .db_x    (db_x),
        .db_x1   (db_x1),
        .both_err(both_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } ev_t;

    ev_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [1:0] exp_db = 2'b00;
    int nx = 0, nx1 = 0, nb = 0;
    int last_x_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                     name, cyc, act, exp);
        end
    endtask

    // Reference model: per channel, the pin history since reset.
    // The level seen downstream at an edge is the pin two edges back.
    // The level flips after N consecutive differing samples; a press
    // counts only once a real released sample has been observed.
    bit hist0[$];
    bit hist1[$];
    bit m_st[2];
    bit m_arm[2];
    int m_run[2];

    initial begin
        forever begin
            bit r[2];
            bit s;
            bit b;
            int n;
            @(posedge CLK);
            cyc++;
            if (!RST) begin
                hist0.delete();
                hist1.delete();
                for (int ch = 0; ch < 2; ch++) begin
                    m_st[ch]  = 1'b0;
                    m_arm[ch] = 1'b0;
                    m_run[ch] = 0;
                end
                exp_db = 2'b00;
            end else begin
                for (int ch = 0; ch < 2; ch++) begin
                    r[ch] = 1'b0;
                    n = (ch == 0) ? hist0.size() : hist1.size();
                    b = (ch == 0) ? btn_x : btn_x1;
                    if (n >= 2) begin
                        s = (ch == 0) ? hist0[n-2] : hist1[n-2];
                        if (s == m_st[ch]) begin
                            m_run[ch] = 0;
                        end else if (m_run[ch] == N - 1) begin
                            r[ch] = s & m_arm[ch];
                            m_st[ch] = s;
                            m_run[ch] = 0;
                        end else begin
                            m_run[ch]++;
                        end
                        if (!s) m_arm[ch] = 1'b1;
                    end
                    if (ch == 0) hist0.push_back(b);
                    else hist1.push_back(b);
                end
                exp_db = {m_st[1], m_st[0]};
                if (r[0] | r[1]) begin
                    ev_t e;
                    e.cyc  = cyc;
                    e.kind = (r[0] & r[1]) ? 3'b100 : {1'b0, r[1], r[0]};
                    q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares levels each cycle and pops expected pulses.
    initial begin
        forever begin
            logic [2:0] act;
            ev_t e;
            @(negedge CLK);
            act = {both_err, x1, x};
            if (act[0]) begin
                nx++;
                last_x_cyc = cyc;
            end
            if (act[1]) nx1++;
            if (act[2]) nb++;
            chk("db_levels", int'({db_x1, db_x}), int'(exp_db));
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("pulse", int'(act), int'(e.kind));
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("pulse_stale", int'(act), int'(e.kind));
            end else if (act != 3'b000) begin
                chk("pulse_spurious", int'(act), 0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int bx, bx1, bb, p;

        // Reset state
        RST = 1'b0;
        cycles(3);
        chk("reset_out",
            int'({both_err, x1, x, db_x1, db_x}), 0);
        RST = 1'b1;
        cycles(4);

        // Clean press
        bx = nx; bx1 = nx1; bb = nb;
        p = cyc + 1;
        btn_x = 1'b1;
        cycles(20);
        chk("clean_count", nx - bx, 1);
        chk("clean_latency", last_x_cyc, p + N + 1);
        chk("clean_db", int'(db_x), 1);
        chk("clean_other", (nx1 - bx1) + (nb - bb), 0);
        btn_x = 1'b0;
        cycles(12);
        chk("release_nopulse", nx - bx, 1);

        // Bounce then hold
        bx = nx;
        for (int i = 0; i < 4; i++) begin
            btn_x = (i % 2 == 0);
            cycles(1);
        end
        btn_x = 1'b1;
        p = cyc + 1;
        cycles(15);
        chk("bounce_count", nx - bx, 1);
        chk("bounce_latency", last_x_cyc, p + N + 1);
        btn_x = 1'b0;
        cycles(12);

        // Short glitch on x1
        bx1 = nx1;
        btn_x1 = 1'b1;
        cycles(N - 1);
        btn_x1 = 1'b0;
        cycles(10);
        chk("glitch_count", nx1 - bx1, 0);
        chk("glitch_db", int'(db_x1), 0);

        // Simultaneous press
        bx = nx; bx1 = nx1; bb = nb;
        btn_x = 1'b1;
        btn_x1 = 1'b1;
        cycles(15);
        chk("both_err_count", nb - bb, 1);
        chk("both_no_x", (nx - bx) + (nx1 - bx1), 0);
        btn_x = 1'b0;
        btn_x1 = 1'b0;
        cycles(12);

        // Held through reset
        bx = nx;
        btn_x = 1'b1;
        RST = 1'b0;
        cycles(3);
        RST = 1'b1;
        cycles(20);
        chk("held_rst_nopulse", nx - bx, 0);
        chk("held_rst_db", int'(db_x), 1);
        btn_x = 1'b0;
        cycles(12);
        btn_x = 1'b1;
        cycles(15);
        chk("held_rst_repress", nx - bx, 1);
        btn_x = 1'b0;
        cycles(12);

        // Reset mid-debounce
        bx = nx;
        btn_x = 1'b1;
        cycles(3);
        RST = 1'b0;
        cycles(1);
        chk("mid_rst_out",
            int'({both_err, x1, x, db_x1, db_x}), 0);
        RST = 1'b1;
        cycles(20);
        chk("mid_rst_nopulse", nx - bx, 0);
        btn_x = 1'b0;
        cycles(12);

        // Random phases of busy and quiet button activity
        for (int i = 0; i < 800; i++) begin
            int lim;
            lim = ((i / 60) % 2 == 0) ? 2 : 11;
            if ($urandom_range(0, lim) == 0) btn_x = ~btn_x;
            if ($urandom_range(0, lim) == 0) btn_x1 = ~btn_x1;
            RST = ($urandom_range(0, 199) != 0);
            cycles(1);
        end
        RST = 1'b1;
        btn_x = 1'b0;
        btn_x1 = 1'b0;
        cycles(15);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
